// File: rtl/multicycle_ctrl_seq_if.sv
// Handshake/bus bundle between the multi-cycle sequencer and the datapath.
// The master side drives instruction/flag inputs; the slave (sequencer) drives PC and controls.
interface multicycle_ctrl_seq_if;
   logic        start;
   logic [31:0] ins;
   logic        zero;
   logic [31:0] branch;
   logic [31:0] jTarget;
   logic [31:0] PCin;
   logic        RegWrite;
   logic        ALUSrc;
   logic        MemRead;
   logic        MemWrite;
   logic        Mem2Reg;
   logic [2:0]  op;
   logic        busy;
   logic        done;
   logic        illegal;
   logic [15:0] retired;

   modport master (
      output start, ins, zero, branch, jTarget,
      input  PCin, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op, busy, done, illegal,
             retired
   );

   modport slave (
      input  start, ins, zero, branch, jTarget,
      output PCin, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op, busy, done, illegal,
             retired
   );
endinterface

// File: rtl/multicycle_ctrl_seq.sv
// Multi-cycle RISC-V control sequencer: owns the PC and steps FETCH..WB one instruction at a time.
// Optional bne support is enabled by defining MULTICYCLE_CTRL_SEQ_BNE_EN.
module multicycle_ctrl_seq #(
   parameter logic [31:0] RESET_PC = 32'h28
) (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_ctrl_seq_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
   } state_e;

   typedef enum logic [2:0] {
      ClsAlu, ClsLoad, ClsStore, ClsBeq, ClsBne, ClsJal
   } cls_e;

   state_e      state_q;
   cls_e        cls_q;
   logic [31:0] pc_q, ir_q, npc_q;
   logic [2:0]  op_q;
   logic        alusrc_q, m2r_q, memread_q, memwrite_q, regwrite_q;
   logic        busy_q, done_q, illegal_q;
   logic [15:0] retired_q;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        dec_ok, dec_zero, dec_alusrc, dec_m2r;
   logic [2:0]  dec_op;
   cls_e        dec_cls;
   logic [31:0] npc_exec;

   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];
   assign funct7 = ir_q[31:25];

   always_comb begin
      dec_ok     = 1'b1;
      dec_zero   = (ir_q == 32'h0);
      dec_op     = 3'b010;
      dec_alusrc = 1'b0;
      dec_m2r    = 1'b0;
      dec_cls    = ClsAlu;
      case (opcode)
         7'h33: begin
            case (funct3)
               3'b000: begin
                  if (funct7 == 7'h00)      dec_op = 3'b010;
                  else if (funct7 == 7'h20) dec_op = 3'b110;
                  else                      dec_ok = 1'b0;
               end
               3'b110:  dec_op = 3'b001;
               3'b111:  dec_op = 3'b000;
               default: dec_ok = 1'b0;
            endcase
         end
         7'h13: begin
            dec_alusrc = 1'b1;
            dec_ok     = (funct3 == 3'b000);
         end
         7'h03: begin
            dec_alusrc = 1'b1;
            dec_m2r    = 1'b1;
            dec_cls    = ClsLoad;
            dec_ok     = (funct3 == 3'b010);
         end
         7'h23: begin
            dec_alusrc = 1'b1;
            dec_cls    = ClsStore;
            dec_ok     = (funct3 == 3'b010);
         end
         7'h63: begin
            dec_op = 3'b110;
            if (funct3 == 3'b000) dec_cls = ClsBeq;
`ifdef MULTICYCLE_CTRL_SEQ_BNE_EN
            else if (funct3 == 3'b001) dec_cls = ClsBne;
`endif
            else dec_ok = 1'b0;
         end
         7'h6F: begin
            dec_alusrc = 1'b1;
            dec_cls    = ClsJal;
         end
         default: dec_ok = 1'b0;
      endcase
   end

   // zero/branch/jTarget are only meaningful at the EXEC exit edge
   always_comb begin
      npc_exec = pc_q + 32'd4;
      case (cls_q)
         ClsBeq:  if (bus.zero)  npc_exec = pc_q + (bus.branch << 2);
         ClsBne:  if (!bus.zero) npc_exec = pc_q + (bus.branch << 2);
         ClsJal:  npc_exec = pc_q + (bus.jTarget << 2);
         default: npc_exec = pc_q + 32'd4;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cls_q      <= ClsAlu;
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         npc_q      <= '0;
         op_q       <= 3'b010;
         alusrc_q   <= 1'b0;
         m2r_q      <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         regwrite_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
         retired_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q <= StFetch;
                  busy_q  <= 1'b1;
               end
            end
            StFetch: begin
               ir_q    <= bus.ins;
               state_q <= StDecode;
            end
            StDecode: begin
               if (dec_zero || !dec_ok) begin
                  state_q   <= StHalt;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  illegal_q <= !dec_zero;
               end else begin
                  state_q  <= StExec;
                  cls_q    <= dec_cls;
                  op_q     <= dec_op;
                  alusrc_q <= dec_alusrc;
                  m2r_q    <= dec_m2r;
               end
            end
            StExec: begin
               npc_q <= npc_exec;
               case (cls_q)
                  ClsLoad: begin
                     state_q   <= StMem;
                     memread_q <= 1'b1;
                  end
                  ClsStore: begin
                     state_q    <= StMem;
                     memwrite_q <= 1'b1;
                  end
                  ClsBeq, ClsBne: begin
                     state_q   <= StFetch;
                     pc_q      <= npc_exec;
                     retired_q <= retired_q + 16'd1;
                  end
                  default: begin
                     state_q    <= StWb;
                     regwrite_q <= 1'b1;
                  end
               endcase
            end
            StMem: begin
               memread_q  <= 1'b0;
               memwrite_q <= 1'b0;
               if (cls_q == ClsLoad) begin
                  state_q    <= StWb;
                  regwrite_q <= 1'b1;
               end else begin
                  state_q   <= StFetch;
                  pc_q      <= npc_q;
                  retired_q <= retired_q + 16'd1;
               end
            end
            StWb: begin
               regwrite_q <= 1'b0;
               state_q    <= StFetch;
               pc_q       <= npc_q;
               retired_q  <= retired_q + 16'd1;
            end
            StHalt: state_q <= StHalt;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.PCin     = pc_q;
   assign bus.RegWrite = regwrite_q;
   assign bus.ALUSrc   = alusrc_q;
   assign bus.MemRead  = memread_q;
   assign bus.MemWrite = memwrite_q;
   assign bus.Mem2Reg  = m2r_q;
   assign bus.op       = op_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.illegal  = illegal_q;
   assign bus.retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Self-checking bench for multicycle_ctrl_seq: directed scenarios plus a randomized program
// compared against an instruction-level reference model.
module tb_multicycle_ctrl_seq;

   localparam int KAdd = 0, KSub = 1, KOr = 2, KAnd = 3, KAddi = 4, KLw = 5, KSw = 6,
                  KBeq = 7, KJal = 8, KBne = 9, KHalt = 10, KIll = 11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [2:0]  obs_str[0:4];   // {MemRead, MemWrite, RegWrite}
   logic [4:0]  obs_ctl[0:4];   // {op, ALUSrc, Mem2Reg}
   logic [31:0] obs_pc[0:4];
   logic        obs_busy[0:4];
   logic [31:0] obs_npc;
   logic [15:0] obs_ret;

   multicycle_ctrl_seq_if bus();

   multicycle_ctrl_seq #(.RESET_PC(32'h28)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic int kind_of(input logic [31:0] i);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      opc = i[6:0];
      f3  = i[14:12];
      f7  = i[31:25];
      if (i == 32'h0) return KHalt;
      if (opc == 7'h33 && f3 == 3'b000 && f7 == 7'h00) return KAdd;
      if (opc == 7'h33 && f3 == 3'b000 && f7 == 7'h20) return KSub;
      if (opc == 7'h33 && f3 == 3'b110) return KOr;
      if (opc == 7'h33 && f3 == 3'b111) return KAnd;
      if (opc == 7'h13 && f3 == 3'b000) return KAddi;
      if (opc == 7'h03 && f3 == 3'b010) return KLw;
      if (opc == 7'h23 && f3 == 3'b010) return KSw;
      if (opc == 7'h63 && f3 == 3'b000) return KBeq;
`ifdef MULTICYCLE_CTRL_SEQ_BNE_EN
      if (opc == 7'h63 && f3 == 3'b001) return KBne;
`endif
      if (opc == 7'h6F) return KJal;
      return KIll;
   endfunction

   function automatic int latency(input int k);
      if (k == KBeq || k == KBne) return 3;
      if (k == KLw) return 5;
      return 4;
   endfunction

   function automatic logic [4:0] exp_ctl(input int k);
      logic [2:0] o;
      logic       s, m;
      o = 3'b010;
      if (k == KSub || k == KBeq || k == KBne) o = 3'b110;
      if (k == KOr)  o = 3'b001;
      if (k == KAnd) o = 3'b000;
      s = (k == KAddi || k == KLw || k == KSw || k == KJal);
      m = (k == KLw);
      return {o, s, m};
   endfunction

   function automatic logic [2:0] exp_strobe(input int k, input int cyc);
      if (cyc == 3 && k == KLw) return 3'b100;
      if (cyc == 3 && k == KSw) return 3'b010;
      if (cyc == 3 && k != KBeq && k != KBne && k != KLw) return 3'b001;
      if (cyc == 4 && k == KLw) return 3'b001;
      return 3'b000;
   endfunction

   function automatic logic [31:0] exp_npc(input logic [31:0] pc, input int k, input logic z,
                                           input logic [31:0] b, input logic [31:0] j);
      if (k == KBeq && z)  return pc + b * 32'd4;
      if (k == KBne && !z) return pc + b * 32'd4;
      if (k == KJal)       return pc + j * 32'd4;
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] rand_instr(input int sel);
      logic [31:0] r;
      r = $urandom;
      case (sel)
         0: begin r[6:0] = 7'h33; r[14:12] = 3'b000; r[31:25] = 7'h00; end
         1: begin r[6:0] = 7'h33; r[14:12] = 3'b000; r[31:25] = 7'h20; end
         2: begin r[6:0] = 7'h33; r[14:12] = 3'b110; end
         3: begin r[6:0] = 7'h33; r[14:12] = 3'b111; end
         4: begin r[6:0] = 7'h13; r[14:12] = 3'b000; end
         5: begin r[6:0] = 7'h03; r[14:12] = 3'b010; end
         6: begin r[6:0] = 7'h23; r[14:12] = 3'b010; end
         7: begin r[6:0] = 7'h63; r[14:12] = 3'b000; end
         8: r[6:0] = 7'h6F;
         default: begin r[6:0] = 7'h63; r[14:12] = 3'b001; end
      endcase
      return r;
   endfunction

   task automatic do_reset();
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.ins     = '0;
      bus.zero    = 1'b0;
      bus.branch  = '0;
      bus.jTarget = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Called at the negedge of a FETCH cycle; returns at the negedge of the next FETCH.
   task automatic exec_instr(input logic [31:0] i, input logic z, input logic [31:0] b,
                             input logic [31:0] j, input int ncyc);
      bus.ins     = i;
      bus.zero    = z;
      bus.branch  = b;
      bus.jTarget = j;
      for (int k = 0; k < ncyc; k++) begin
         if (k > 0) @(negedge clk);
         obs_str[k]  = {bus.MemRead, bus.MemWrite, bus.RegWrite};
         obs_ctl[k]  = {bus.op, bus.ALUSrc, bus.Mem2Reg};
         obs_pc[k]   = bus.PCin;
         obs_busy[k] = bus.busy;
      end
      @(negedge clk);
      obs_npc = bus.PCin;
      obs_ret = bus.retired;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.PCin !== 32'h28) begin
         failures++; $display("FAIL reset_pc got=%h want=%h", bus.PCin, 32'h28);
      end
      checks++;
      if ({bus.RegWrite, bus.ALUSrc, bus.MemRead, bus.MemWrite, bus.Mem2Reg, bus.op} !== 8'b00000010)
      begin
         failures++; $display("FAIL reset_ctl got=%b want=00000010",
            {bus.RegWrite, bus.ALUSrc, bus.MemRead, bus.MemWrite, bus.Mem2Reg, bus.op});
      end
      checks++;
      if ({bus.busy, bus.done, bus.illegal, bus.retired} !== 19'd0) begin
         failures++; $display("FAIL reset_status got=%b%b%b ret=%0d want=000 ret=0",
            bus.busy, bus.done, bus.illegal, bus.retired);
      end
      // sw interrupted by reset in EXEC
      do_start();
      bus.ins = 32'h00102023;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++; $display("FAIL midrst_busy got=%b want=1", bus.busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.PCin, bus.busy, bus.MemWrite, bus.RegWrite, bus.op} !== {32'h28, 3'b000, 3'b010})
      begin
         failures++; $display("FAIL midrst_async got pc=%h busy=%b mw=%b rw=%b op=%b", bus.PCin,
            bus.busy, bus.MemWrite, bus.RegWrite, bus.op);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if ({bus.MemWrite, bus.RegWrite, bus.busy, bus.PCin} !== {3'b000, 32'h28}) begin
            failures++; $display("FAIL midrst_quiet cyc=%0d mw=%b rw=%b busy=%b pc=%h", c,
               bus.MemWrite, bus.RegWrite, bus.busy, bus.PCin);
         end
      end
   endtask

   task automatic test_add_lw();
      do_reset();
      do_start();
      exec_instr(32'h002081B3, 1'b0, '0, '0, 4);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs_str[k] !== exp_strobe(KAdd, k)) begin
            failures++; $display("FAIL add_strobe cyc=%0d got=%b want=%b", k, obs_str[k],
               exp_strobe(KAdd, k));
         end
      end
      checks++;
      if (obs_ctl[3] !== 5'b01000) begin
         failures++; $display("FAIL add_ctl got=%b want=01000", obs_ctl[3]);
      end
      checks++;
      if (obs_pc[0] !== 32'h28 || obs_npc !== 32'h2C) begin
         failures++; $display("FAIL add_pc got=%h->%h want=28->2c", obs_pc[0], obs_npc);
      end
      exec_instr(32'h00002283, 1'b0, '0, '0, 5);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (obs_str[k] !== exp_strobe(KLw, k)) begin
            failures++; $display("FAIL lw_strobe cyc=%0d got=%b want=%b", k, obs_str[k],
               exp_strobe(KLw, k));
         end
      end
      checks++;
      if (obs_ctl[4] !== 5'b01011) begin
         failures++; $display("FAIL lw_ctl got=%b want=01011", obs_ctl[4]);
      end
      checks++;
      if (obs_npc !== 32'h30 || obs_ret !== 16'd2) begin
         failures++; $display("FAIL lw_retire got pc=%h ret=%0d want pc=30 ret=2", obs_npc,
            obs_ret);
      end
   endtask

   task automatic test_beq();
      do_reset();
      do_start();
      exec_instr(32'h00000063, 1'b1, 32'd3, '0, 3);
      checks++;
      if (obs_npc !== 32'h34 || obs_ctl[2] !== 5'b11000) begin
         failures++; $display("FAIL beq_taken got pc=%h ctl=%b want pc=34 ctl=11000", obs_npc,
            obs_ctl[2]);
      end
      checks++;
      if ((obs_str[0] | obs_str[1] | obs_str[2]) !== 3'b000) begin
         failures++; $display("FAIL beq_strobe got=%b want=000",
            obs_str[0] | obs_str[1] | obs_str[2]);
      end
      do_reset();
      do_start();
      exec_instr(32'h00000063, 1'b0, 32'd3, '0, 3);
      checks++;
      if (obs_npc !== 32'h2C) begin
         failures++; $display("FAIL beq_not_taken got=%h want=2c", obs_npc);
      end
   endtask

   task automatic test_jal();
      do_reset();
      do_start();
      exec_instr(32'h00000063, 1'b1, 32'd6, '0, 3);
      exec_instr(32'h000000EF, 1'b0, '0, 32'hFFFFFFFC, 4);
      checks++;
      if (obs_pc[0] !== 32'h40 || obs_npc !== 32'h30) begin
         failures++; $display("FAIL jal_pc got=%h->%h want=40->30", obs_pc[0], obs_npc);
      end
      checks++;
      if (obs_str[3] !== 3'b001 || obs_ctl[3] !== 5'b01010) begin
         failures++; $display("FAIL jal_wb got str=%b ctl=%b want str=001 ctl=01010",
            obs_str[3], obs_ctl[3]);
      end
   endtask

   task automatic test_halt();
      do_reset();
      do_start();
      bus.ins = 32'h0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.done, bus.illegal, bus.busy} !== 3'b100) begin
         failures++; $display("FAIL halt_zero got done/ill/busy=%b want=100",
            {bus.done, bus.illegal, bus.busy});
      end
      bus.ins = 32'h00000013;
      for (int p = 0; p < 3; p++) begin
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
         @(negedge clk);
      end
      checks++;
      if ({bus.done, bus.busy, bus.PCin, bus.retired} !== {2'b10, 32'h28, 16'd0}) begin
         failures++; $display("FAIL halt_sticky got done=%b busy=%b pc=%h ret=%0d", bus.done,
            bus.busy, bus.PCin, bus.retired);
      end
      do_reset();
      do_start();
      bus.ins = 32'h0000107F;
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if ({bus.done, bus.illegal, bus.busy} !== 3'b110) begin
         failures++; $display("FAIL halt_illegal got done/ill/busy=%b want=110",
            {bus.done, bus.illegal, bus.busy});
      end
   endtask

   task automatic test_bne();
      do_reset();
      do_start();
`ifdef MULTICYCLE_CTRL_SEQ_BNE_EN
      exec_instr(32'h00101063, 1'b0, 32'd2, '0, 3);
      checks++;
      if (obs_npc !== 32'h30) begin
         failures++; $display("FAIL bne_taken got=%h want=30", obs_npc);
      end
`else
      bus.ins    = 32'h00101063;
      bus.branch = 32'd2;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.done, bus.illegal} !== 2'b11) begin
         failures++; $display("FAIL bne_illegal got done/ill=%b want=11",
            {bus.done, bus.illegal});
      end
`endif
   endtask

   task automatic test_random();
      logic [31:0] pc, i, b, j;
      logic [15:0] ret;
      logic        z;
      int          k, n, nsel;
      do_reset();
      do_start();
      pc  = 32'h28;
      ret = '0;
`ifdef MULTICYCLE_CTRL_SEQ_BNE_EN
      nsel = 10;
`else
      nsel = 9;
`endif
      for (int t = 0; t < 60; t++) begin
         i = rand_instr(int'($urandom_range(0, nsel - 1)));
         z = 1'($urandom_range(0, 1));
         b = 32'(int'($urandom_range(0, 16)) - 8);
         j = 32'(int'($urandom_range(0, 16)) - 8);
         bus.start = 1'($urandom_range(0, 1));
         k = kind_of(i);
         n = latency(k);
         exec_instr(i, z, b, j, n);
         for (int c = 0; c < n; c++) begin
            checks++;
            if (obs_str[c] !== exp_strobe(k, c) || obs_pc[c] !== pc || obs_busy[c] !== 1'b1)
            begin
               failures++; $display("FAIL rnd_cycle ins=%h cyc=%0d got str=%b pc=%h busy=%b want str=%b pc=%h busy=1",
                  i, c, obs_str[c], obs_pc[c], obs_busy[c], exp_strobe(k, c), pc);
            end
            if (c >= 2) begin
               checks++;
               if (obs_ctl[c] !== exp_ctl(k)) begin
                  failures++; $display("FAIL rnd_ctl ins=%h cyc=%0d got=%b want=%b", i, c,
                     obs_ctl[c], exp_ctl(k));
               end
            end
         end
         pc  = exp_npc(pc, k, z, b, j);
         ret = ret + 16'd1;
         checks++;
         if (obs_npc !== pc || obs_ret !== ret) begin
            failures++; $display("FAIL rnd_retire ins=%h got pc=%h ret=%0d want pc=%h ret=%0d",
               i, obs_npc, obs_ret, pc, ret);
         end
      end
      bus.start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add_lw();
      test_beq();
      test_jal();
      test_halt();
      test_bne();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
